// File: rtl/lcm_sched.sv
// Round-robin front end that time-shares one external GCD/LCM engine.
// Zero-operand jobs are answered locally; engine jobs are watchdog-guarded.
module lcm_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [2*DATA_WIDTH-1:0]       resp_gcd,
    output logic [2*DATA_WIDTH-1:0]       resp_lcm,
    output logic                          resp_err,
    output logic                          busy,
    output logic                          eng_en,
    output logic [DATA_WIDTH-1:0]         eng_a,
    output logic [DATA_WIDTH-1:0]         eng_b,
    input  logic                          eng_valid,
    input  logic [2*DATA_WIDTH-1:0]       eng_gcd,
    input  logic [2*DATA_WIDTH-1:0]       eng_lcm
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int RW  = 2 * DATA_WIDTH;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FIRE, WAIT, RESP} state_t;

    state_t                state;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        id_q;
    logic [IDW-1:0]        win;
    logic [IDW-1:0]        idx;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] win_a;
    logic [DATA_WIDTH-1:0] win_b;

    // Search starts one past the last winner so every holder is served in turn.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant     = found ? (NUM_REQ'(1) << win) : '0;
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign win_a     = req_a[win*DATA_WIDTH +: DATA_WIDTH];
    assign win_b     = req_b[win*DATA_WIDTH +: DATA_WIDTH];
    assign resp_id   = id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NUM_REQ - 1);
            id_q       <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_gcd   <= '0;
            resp_lcm   <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            eng_en     <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        eng_a <= win_a;
                        eng_b <= win_b;
                        id_q  <= win;
                        ptr   <= win;
                        busy  <= 1'b1;
                        if (win_a == '0 || win_b == '0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_gcd   <= RW'(win_a | win_b);
                            resp_lcm   <= '0;
                            resp_err   <= 1'b0;
                        end else begin
                            state  <= FIRE;
                            eng_en <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    eng_en <= 1'b0;
                    cnt    <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (eng_valid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_gcd   <= eng_gcd;
                        resp_lcm   <= eng_lcm;
                        resp_err   <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_gcd   <= '0;
                        resp_lcm   <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcm_sched.sv
// Scoreboarded random + directed bench for lcm_sched with a model engine.
module tb_lcm_sched;
    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int IDW = 2;
    localparam int RW  = 2 * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [RW-1:0]     resp_gcd;
    logic [RW-1:0]     resp_lcm;
    logic              resp_err;
    logic              busy;
    logic              eng_en;
    logic [DW-1:0]     eng_a;
    logic [DW-1:0]     eng_b;
    logic              eng_valid;
    logic [RW-1:0]     eng_gcd;
    logic [RW-1:0]     eng_lcm;

    lcm_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_gcd(resp_gcd),
        .resp_lcm(resp_lcm), .resp_err(resp_err),
        .busy(busy), .eng_en(eng_en),
        .eng_a(eng_a), .eng_b(eng_b),
        .eng_valid(eng_valid), .eng_gcd(eng_gcd), .eng_lcm(eng_lcm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [RW-1:0] gcd;
        logic [RW-1:0] lcm;
        logic          err;
        logic          zero;
        int            gcyc;
    } exp_t;

    exp_t          sb[$];
    int            glog[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            mptr = N - 1;
    int            fires = 0;
    int            eng_lat_last = 0;
    int            first_grant = -1;
    bit            hang = 0;
    bit            prev_en = 0;
    bit            prev_rv = 0;
    bit            pend[N];
    bit            keep[N];
    int            ja[N];
    int            jb[N];
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [RW-1:0] last_gcd;
    logic [RW-1:0] last_lcm;
    logic          last_err;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [RW-1:0] ref_gcd(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [RW-1:0] x, y, t;
        x = RW'(a);
        y = RW'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [RW-1:0] ref_lcm(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        if (a == 0 || b == 0) return '0;
        return (RW'(a) * RW'(b)) / ref_gcd(a, b);
    endfunction

    function automatic int rnd_op();
        return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requester driver: applies pending jobs just after each rising edge.
    initial begin
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = pend[i];
                req_a[i*DW +: DW] = DW'(ja[i]);
                req_b[i*DW +: DW] = DW'(jb[i]);
            end
        end
    end

    // Model engine: computes from live operands after a random delay.
    initial begin
        int lat;
        eng_valid = 0;
        eng_gcd = '0;
        eng_lcm = '0;
        forever begin
            @(negedge clk);
            if (eng_en && !rst) begin
                check("eng_a_at_fire", eng_a, exp_a);
                check("eng_b_at_fire", eng_b, exp_b);
                if (!hang) begin
                    lat = $urandom_range(1, 8);
                    eng_lat_last = lat;
                    repeat (lat) @(posedge clk);
                    #1;
                    if (!rst) begin
                        check("eng_a_held", eng_a, exp_a);
                        check("eng_b_held", eng_b, exp_b);
                        eng_gcd = ref_gcd(eng_a, eng_b);
                        eng_lcm = ref_lcm(eng_a, eng_b);
                        eng_valid = 1;
                        @(posedge clk);
                        #1;
                        eng_valid = 0;
                    end
                end
            end
        end
    end

    // Monitor: grant order, handshake scoreboard, latency, pulse width.
    always @(negedge clk) begin
        exp_t e;
        int   ew;
        int   el;
        if (!rst) begin
            check("req_ready_onehot", $countones(req_ready) <= 1, 1);
            if (eng_en) begin
                fires++;
                check("eng_en_single", prev_en, 0);
            end
            if (resp_valid && !prev_rv && sb.size() > 0) begin
                el = sb[0].zero ? 1 : (sb[0].err ? TO + 2 : eng_lat_last + 2);
                check("resp_latency", cyc - sb[0].gcyc, el);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", resp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_gcd", resp_gcd, e.gcd);
                    check("resp_lcm", resp_lcm, e.lcm);
                    check("resp_err", resp_err, e.err);
                    check("engine_fires", fires, e.zero ? 0 : 1);
                    last_gcd = resp_gcd;
                    last_lcm = resp_lcm;
                    last_err = resp_err;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ew = -1;
                    for (int k = 1; k <= N; k++)
                        if (ew < 0 && req_valid[(mptr + k) % N]) ew = (mptr + k) % N;
                    check("grant_winner", i, ew);
                    check("busy_at_grant", busy, 0);
                    exp_a = req_a[i*DW +: DW];
                    exp_b = req_b[i*DW +: DW];
                    e.id = i;
                    e.zero = (exp_a == 0 || exp_b == 0);
                    e.err = !e.zero && hang;
                    e.gcd = e.err ? '0 : ref_gcd(exp_a, exp_b);
                    e.lcm = e.err ? '0 : ref_lcm(exp_a, exp_b);
                    e.gcyc = cyc;
                    sb.push_back(e);
                    glog.push_back(i);
                    if (first_grant < 0) first_grant = i;
                    mptr = i;
                    fires = 0;
                    if (keep[i]) begin
                        ja[i] = rnd_op();
                        jb[i] = rnd_op();
                    end else begin
                        pend[i] = 0;
                    end
                end
            end
            prev_en = eng_en;
            prev_rv = resp_valid;
        end else begin
            prev_en = 0;
            prev_rv = 0;
        end
    end

    task automatic check_zero();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_gcd", resp_gcd, 0);
        check("rst_resp_lcm", resp_lcm, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_en", eng_en, 0);
        check("rst_eng_a", eng_a, 0);
        check("rst_eng_b", eng_b, 0);
    endtask

    task automatic clear_model();
        sb.delete();
        glog.delete();
        mptr = N - 1;
        first_grant = -1;
        fires = 0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (t < 3000 &&
                   (pend.or() != 0 || sb.size() != 0 || busy || req_valid != 0));
        if (t >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_%s: still busy after %0d cycles, %0d queued",
                     tag, t, sb.size());
        end
    endtask

    task automatic job(input int i, input int a, input int b);
        ja[i] = a;
        jb[i] = b;
        pend[i] = 1;
    endtask

    initial begin
        logic [RW-1:0] sg, sl;
        logic [IDW-1:0] sid;
        logic           se;
        int             t;
        rst = 1;
        resp_ready = 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; keep[i] = 0; ja[i] = 0; jb[i] = 0;
        end
        pend[1] = 1; ja[1] = 3; jb[1] = 5;
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        pend[1] = 0;
        clear_model();
        @(negedge clk);
        rst = 0;
        repeat (2) @(posedge clk);

        job(0, 12, 18);
        wait_idle("t1");
        check("t1_gcd", last_gcd, 6);
        check("t1_lcm", last_lcm, 36);

        rst = 1;
        repeat (2) @(posedge clk);
        clear_model();
        for (int i = 0; i < N; i++) begin
            keep[i] = 1;
            job(i, rnd_op(), rnd_op());
        end
        @(negedge clk);
        rst = 0;
        t = 0;
        while (glog.size() < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < N; i++) keep[i] = 0;
        for (int k = 0; k < 5; k++)
            check("t2_order", (k < glog.size()) ? glog[k] : -1, k % N);
        wait_idle("t2");

        job(2, 0, 9);
        wait_idle("t3");
        check("t3_gcd", last_gcd, 9);
        check("t3_lcm", last_lcm, 0);

        hang = 1;
        job(1, 10, 4);
        wait_idle("t4a");
        check("t4_err", last_err, 1);
        hang = 0;
        job(1, 7, 5);
        wait_idle("t4b");
        check("t4_lcm", last_lcm, 35);

        resp_ready = 0;
        job(3, 6, 4);
        t = 0;
        while (!resp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_resp_seen", resp_valid, 1);
        job(0, 8, 12);
        job(1, 0, 0);
        sid = resp_id; sg = resp_gcd; sl = resp_lcm; se = resp_err;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_valid_hold", resp_valid, 1);
            check("t5_data_hold", {resp_id, resp_gcd, resp_lcm, resp_err},
                  {sid, sg, sl, se});
            check("t5_no_grant", req_ready, 0);
            check("t5_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1;
        @(negedge clk);
        check("t5_no_same_cycle_grant", req_ready, 0);
        @(negedge clk);
        check("t5_grant_next", req_ready != 0, 1);
        wait_idle("t5");

        hang = 1;
        job(3, 5, 7);
        t = 0;
        while (!eng_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        #2;
        rst = 1;
        #1;
        check_zero();
        for (int i = 0; i < N; i++) job(i, i + 1, 2 * i + 3);
        clear_model();
        repeat (2) @(posedge clk);
        hang = 0;
        @(negedge clk);
        rst = 0;
        wait_idle("t6");
        check("t6_first_grant", first_grant, 0);

        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 5) == 0) job(i, rnd_op(), rnd_op());
        end
        resp_ready = 1;
        wait_idle("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: run did not finish, %0d queued", sb.size());
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lcm_sched.md
Name: lcm_sched

Overview:
- Shares one GCD/LCM compute engine among NUM_REQ requesters and sequences it.
- Per-requester valid/ready request ports feed a round-robin arbiter.
- The winning job's operands are latched and held on the engine inputs, and the engine is fired with a single-cycle enable.
- The block waits for the engine's done pulse, guarded by a watchdog, then returns results on a single tagged response port with backpressure.
- Zero operands are resolved locally, never sent to the engine.

Parameters:
- DATA_WIDTH, 8: operand width; results are 2*DATA_WIDTH.
- NUM_REQ, 4: number of requesters, 2..16.
- TIMEOUT, 64: maximum cycles spent in WAIT before a job is aborted with error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high. The engine's active-low reset is tied to ~rst at the top level.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*DATA_WIDTH  operand a; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand b; same slicing as req_a.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- resp_gcd  out  2*DATA_WIDTH  greatest common divisor.
- resp_lcm  out  2*DATA_WIDTH  least common multiple.
- resp_err  out  1  job aborted by the watchdog.
- busy  out  1  high in any state other than IDLE.
- eng_en  out  1  engine enable; the engine detects it on the rising edge.
- eng_a  out  DATA_WIDTH  engine operand a.
- eng_b  out  DATA_WIDTH  engine operand b.
- eng_valid  in  1  engine done pulse, one cycle wide.
- eng_gcd  in  2*DATA_WIDTH  engine GCD result, valid with eng_valid.
- eng_lcm  in  2*DATA_WIDTH  engine LCM result, valid with eng_valid.

Behaviour:

Reset (rst=1, asynchronous):
- State goes to IDLE and the round-robin pointer to NUM_REQ-1, so requester 0 has first priority.
- Every output is 0: req_ready, resp_*, busy, eng_en, eng_a, eng_b.
- Reset mid-job discards the job with no response; the engine is reset concurrently.

State machine (IDLE, FIRE, WAIT, RESP):

IDLE:
- The arbiter searches req_valid starting at ptr+1 mod NUM_REQ.
- req_ready is driven combinationally, one-hot to the winner; it is 0 when no request is pending and always 0 outside IDLE.
- On handshake:
  - latch a, b and id into eng_a, eng_b and the id register;
  - set ptr to the winner;
  - if a==0 or b==0, go to RESP with gcd = a|b zero-extended, lcm = 0, err = 0;
  - otherwise go to FIRE.

FIRE:
- eng_en=1 for exactly this one cycle, then WAIT.
- The watchdog counter clears to 0.

WAIT:
- eng_en=0; eng_a and eng_b stay stable, because the engine computes its product from live operands.
- The counter increments every cycle.
- If eng_valid=1: capture eng_gcd and eng_lcm, set err=0, go to RESP.
- Else if the counter reaches TIMEOUT-1: set gcd=0, lcm=0, err=1, go to RESP.
- If eng_valid and timeout occur in the same cycle, eng_valid wins.

RESP:
- resp_valid=1, with resp_id, resp_gcd, resp_lcm and resp_err held stable.
- On resp_ready=1: go to IDLE. No new grant is issued in the same cycle; the earliest next grant is the following cycle.
- eng_a and eng_b hold their values until the next grant.

Other rules:
- eng_valid is ignored outside WAIT.
- Exactly one job is in flight at a time.
- All outputs except req_ready are registered.
- Latency from the grant cycle to resp_valid:
  - zero-operand job: 1 cycle;
  - engine job: 2 cycles plus the engine's done latency measured from its eng_en.
- Fairness: a requester that holds req_valid is granted within NUM_REQ grants.
- req_valid[i] may drop while not granted; the block requires nothing of it.

Test Plan:
1. Requester 0 sends a=12, b=18 with a model engine → eng_en is high for exactly 1 cycle and eng_a/eng_b are held at 12/18 through WAIT; the response has id=0, gcd=6, lcm=36, err=0.
2. All 4 requesters hold req_valid after reset, with resp_ready=1 → grants occur in order 0,1,2,3,0, each response id matches its grant, and there are never two req_ready bits high.
3. Requester 2 sends a=0, b=9 → the engine is not fired (eng_en stays 0); the response has gcd=9, lcm=0, err=0 and resp_valid rises 1 cycle after the grant.
4. The engine model never pulses eng_valid → after 64 cycles in WAIT the response has err=1, gcd=0, lcm=0; the next request still completes normally.
5. resp_ready is held low for 10 cycles with new requests pending → resp_valid and its data stay stable, req_ready stays 0 and busy stays 1; the first grant appears the cycle after the handshake.
6. rst is asserted during WAIT → all outputs go to 0 immediately, the state is IDLE, no response is emitted, and the first grant after reset goes to requester 0.
